// File: rtl/Falco_pkg.sv
// Falco_pkg: shared fetch-side types and constants for the Falco front end.
package Falco_pkg;
    typedef logic [31:0] raw_instruction_t;
    typedef logic [31:0] pc_t;
    typedef logic [7:0]  BHSR_t;
    localparam int IFB_DEPTH = 8;
    typedef struct packed {
        raw_instruction_t instr;
        pc_t              pc;
        BHSR_t            bhsr;
    } fetch_entry_t;
endpackage

// File: rtl/ifb_entry_ram.sv
// ifb_entry_ram: DEPTH-entry fetch buffer storage, two write ports, two combinational read ports.
module ifb_entry_ram import Falco_pkg::*; #(
    parameter int DEPTH = IFB_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we0,
    input  logic [AW-1:0] wa0,
    input  fetch_entry_t wd0,
    input  logic         we1,
    input  logic [AW-1:0] wa1,
    input  fetch_entry_t wd1,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    output fetch_entry_t rd0,
    output fetch_entry_t rd1
);
    fetch_entry_t mem [DEPTH];
    // Write addresses are always distinct (tail and tail+1), so port order is irrelevant.
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end
    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: dual-issue in-order fetch FIFO between fetch and decode.
// Define FALCO_IFB_STATS_EN to add saturating stall_cycles / flush_count counters.
module instr_fetch_buffer import Falco_pkg::*; #(
    parameter int DEPTH = IFB_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in0_valid,
    input  logic             in1_valid,
    input  raw_instruction_t in0_instr,
    input  raw_instruction_t in1_instr,
    input  pc_t              in0_pc,
    input  pc_t              in1_pc,
    input  BHSR_t            in0_bhsr,
    input  BHSR_t            in1_bhsr,
    output logic             in_ready,
    output logic             out0_valid,
    output logic             out1_valid,
    output raw_instruction_t out0_instr,
    output raw_instruction_t out1_instr,
    output pc_t              out0_pc,
    output pc_t              out1_pc,
    output BHSR_t            out0_bhsr,
    output BHSR_t            out1_bhsr,
    input  logic [1:0]       dec_take,
`ifdef FALCO_IFB_STATS_EN
    output logic [CW-1:0]    count,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
`else
    output logic [CW-1:0]    count
`endif
);
    logic [AW-1:0] head, tail;
    logic          wr;
    logic [1:0]    n_wr, take_req, take;
    fetch_entry_t  rd0, rd1;
    assign in_ready = count <= CW'(DEPTH - 2);
    assign wr       = in_ready & ~flush;
    assign n_wr     = wr ? {1'b0, in0_valid} + {1'b0, in1_valid} : 2'd0;
    // Decode may ask for more than is present; clamp so head never passes tail.
    assign take_req = dec_take[1] ? 2'd2 : dec_take;
    assign take     = CW'(take_req) > count ? count[1:0] : take_req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(take);
            tail  <= tail + AW'(n_wr);
            count <= count + CW'(n_wr) - CW'(take);
        end
    end
    // A lone slot-1 instruction is compacted onto tail.
    ifb_entry_ram #(.DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .we0 (wr & in0_valid),
        .wa0 (tail),
        .wd0 ('{instr: in0_instr, pc: in0_pc, bhsr: in0_bhsr}),
        .we1 (wr & in1_valid),
        .wa1 (tail + AW'(in0_valid)),
        .wd1 ('{instr: in1_instr, pc: in1_pc, bhsr: in1_bhsr}),
        .ra0 (head),
        .ra1 (head + AW'(1)),
        .rd0 (rd0),
        .rd1 (rd1)
    );
    assign out0_valid = count >= CW'(1);
    assign out1_valid = count >= CW'(2);
    assign out0_instr = rd0.instr;
    assign out0_pc    = rd0.pc;
    assign out0_bhsr  = rd0.bhsr;
    assign out1_instr = rd1.instr;
    assign out1_pc    = rd1.pc;
    assign out1_bhsr  = rd1.bhsr;
`ifdef FALCO_IFB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (~in_ready & (in0_valid | in1_valid) & ~&stall_cycles) stall_cycles <= stall_cycles + 32'd1;
            if (flush & ~&flush_count) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed and randomized checks of instr_fetch_buffer against a queue model.
module tb_instr_fetch_buffer;
    import Falco_pkg::*;
    localparam int DEPTH = 8;
    logic clk = 0, rst_n = 0, flush = 0, in0_valid = 0, in1_valid = 0;
    raw_instruction_t in0_instr = '0, in1_instr = '0, out0_instr, out1_instr;
    pc_t in0_pc = '0, in1_pc = '0, out0_pc, out1_pc;
    BHSR_t in0_bhsr = '0, in1_bhsr = '0, out0_bhsr, out1_bhsr;
    logic [1:0] dec_take = '0;
    logic in_ready, out0_valid, out1_valid;
    logic [$clog2(DEPTH):0] count;
`ifdef FALCO_IFB_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif
    int passed = 0, total = 0;
    fetch_entry_t q[$];

    always #5 clk = ~clk;

    instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_instr(in0_instr), .in1_instr(in1_instr),
        .in0_pc(in0_pc), .in1_pc(in1_pc),
        .in0_bhsr(in0_bhsr), .in1_bhsr(in1_bhsr),
        .in_ready(in_ready), .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out0_instr(out0_instr), .out1_instr(out1_instr),
        .out0_pc(out0_pc), .out1_pc(out1_pc),
        .out0_bhsr(out0_bhsr), .out1_bhsr(out1_bhsr),
        .dec_take(dec_take),
`ifdef FALCO_IFB_STATS_EN
        .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
        .count(count)
    );

    task automatic drive(input logic v0, input logic v1, input pc_t p0, input pc_t p1,
                         input logic [1:0] t, input logic f);
        in0_valid = v0; in1_valid = v1; in0_pc = p0; in1_pc = p1;
        in0_instr = $urandom; in1_instr = $urandom;
        in0_bhsr = BHSR_t'($urandom); in1_bhsr = BHSR_t'($urandom);
        dec_take = t; flush = f;
    endtask

    // Advance the FIFO model by one clock using the currently driven inputs, then clock the DUT.
    task automatic step();
        int n;
        bit room;
        room = (DEPTH - q.size()) >= 2;
        if (flush) q.delete();
        else begin
            n = (int'(dec_take) < q.size()) ? int'(dec_take) : q.size();
            repeat (n) void'(q.pop_front());
            if (room && in0_valid) q.push_back('{instr: in0_instr, pc: in0_pc, bhsr: in0_bhsr});
            if (room && in1_valid) q.push_back('{instr: in1_instr, pc: in1_pc, bhsr: in1_bhsr});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 2'd0, 0);
    endtask

    task automatic drain();
        drive(0, 0, '0, '0, 2'd2, 0);
        repeat (DEPTH / 2) step();
        idle();
    endtask

    task automatic test_reset();
        #1;
        total++; if (count !== 0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out0_valid !== 1'b0) $display("FAIL reset_out0_valid: got %b expected 0", out0_valid); else passed++;
        total++; if (out1_valid !== 1'b0) $display("FAIL reset_out1_valid: got %b expected 0", out1_valid); else passed++;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_dual_write();
        drive(1, 1, 32'h100, 32'h104, 2'd0, 0); step(); idle();
        total++; if (out0_pc !== 32'h100) $display("FAIL dual_out0_pc: got %h expected 100", out0_pc); else passed++;
        total++; if (out1_pc !== 32'h104) $display("FAIL dual_out1_pc: got %h expected 104", out1_pc); else passed++;
        total++; if (count !== 2) $display("FAIL dual_count: got %0d expected 2", count); else passed++;
        total++; if (out0_instr !== q[0].instr) $display("FAIL dual_out0_instr: got %h expected %h", out0_instr, q[0].instr); else passed++;
        drain();
    endtask

    task automatic test_single_slot1();
        drive(0, 1, '0, 32'h204, 2'd0, 0); step(); idle();
        total++; if (out0_pc !== 32'h204) $display("FAIL slot1_out0_pc: got %h expected 204", out0_pc); else passed++;
        total++; if (out1_valid !== 1'b0) $display("FAIL slot1_out1_valid: got %b expected 0", out1_valid); else passed++;
        total++; if (count !== 1) $display("FAIL slot1_count: got %0d expected 1", count); else passed++;
        drain();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h300 + 32'(8 * i), 32'h304 + 32'(8 * i), 2'd0, 0); step();
        end
        total++; if (count !== 8) $display("FAIL fill_count: got %0d expected 8", count); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", in_ready); else passed++;
        drive(1, 1, 32'h400, 32'h404, 2'd0, 0); step();
        total++; if (count !== 8) $display("FAIL fill_drop_count: got %0d expected 8", count); else passed++;
        total++; if (out0_pc !== 32'h300) $display("FAIL fill_drop_out0_pc: got %h expected 300", out0_pc); else passed++;
        drive(0, 0, '0, '0, 2'd2, 0); step(); idle();
        total++; if (in_ready !== 1'b1) $display("FAIL fill_take_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out0_pc !== 32'h308) $display("FAIL fill_take_out0_pc: got %h expected 308", out0_pc); else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        pc_t p = 32'h1000;
        drive(1, 1, p, p + 4, 2'd0, 0); step();
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1, p + 32'(8 * i), p + 32'(8 * i + 4), 2'd2, 0); step();
            total++;
            if (count !== 2 || out0_pc !== p + 32'(8 * i) || out1_pc !== p + 32'(8 * i + 4))
                $display("FAIL b2b_%0d: got count=%0d pcs=%h/%h expected count=2 pcs=%h/%h",
                         i, count, out0_pc, out1_pc, p + 32'(8 * i), p + 32'(8 * i + 4));
            else passed++;
        end
        drain();
    endtask

    task automatic test_flush();
        drive(1, 1, 32'h500, 32'h504, 2'd0, 0); step();
        drive(1, 1, 32'h508, 32'h50c, 2'd0, 0); step();
        drive(1, 0, 32'h510, '0, 2'd0, 0); step();
        total++; if (count !== 5) $display("FAIL flush_pre_count: got %0d expected 5", count); else passed++;
        drive(1, 1, 32'h600, 32'h604, 2'd1, 1); step(); idle();
        total++; if (count !== 0) $display("FAIL flush_count: got %0d expected 0", count); else passed++;
        total++; if (out0_valid !== 1'b0) $display("FAIL flush_out0_valid: got %b expected 0", out0_valid); else passed++;
    endtask

    task automatic test_underflow();
        drive(1, 0, 32'h700, '0, 2'd0, 0); step();
        drive(0, 0, '0, '0, 2'd2, 0); step();
        total++; if (count !== 0) $display("FAIL underflow_count: got %0d expected 0", count); else passed++;
        step(); idle();
        total++; if (count !== 0 || in_ready !== 1'b1) $display("FAIL underflow_hold: got count=%0d in_ready=%b expected 0/1", count, in_ready); else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 1'($urandom), pc_t'($urandom), pc_t'($urandom),
                  2'($urandom_range(0, 2)), $urandom_range(0, 15) == 0);
            step();
            total++;
            if (int'(count) !== q.size() || in_ready !== ((DEPTH - q.size()) >= 2) ||
                out0_valid !== (q.size() >= 1) || out1_valid !== (q.size() >= 2))
                $display("FAIL rand_ctrl_%0d: got count=%0d in_ready=%b v=%b%b expected count=%0d",
                         i, count, in_ready, out0_valid, out1_valid, q.size());
            else passed++;
            if (q.size() >= 1) begin
                total++;
                if ({out0_instr, out0_pc, out0_bhsr} !== q[0])
                    $display("FAIL rand_out0_%0d: got %h expected %h", i, {out0_instr, out0_pc, out0_bhsr}, q[0]);
                else passed++;
            end
            if (q.size() >= 2) begin
                total++;
                if ({out1_instr, out1_pc, out1_bhsr} !== q[1])
                    $display("FAIL rand_out1_%0d: got %h expected %h", i, {out1_instr, out1_pc, out1_bhsr}, q[1]);
                else passed++;
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive(1, 1, 32'h800, 32'h804, 2'd0, 0); step();
        drive(1, 1, 32'h808, 32'h80c, 2'd1, 0);
        #2 rst_n = 0;
        #1;
        q.delete();
        total++; if (count !== 0) $display("FAIL areset_count: got %0d expected 0", count); else passed++;
        total++; if (out0_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL areset_flags: got v=%b rdy=%b expected 0/1", out0_valid, in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (count !== 0) $display("FAIL areset_held_count: got %0d expected 0", count); else passed++;
        idle();
        #2 rst_n = 1;
        drive(0, 1, '0, 32'h900, 2'd0, 0); step(); idle();
        total++; if (count !== 1 || out0_pc !== 32'h900) $display("FAIL areset_recover: got count=%0d pc=%h expected 1/900", count, out0_pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_single_slot1();
        test_fill();
        test_back_to_back();
        test_flush();
        test_underflow();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer entries; power of two, minimum 4.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all buffered entries.
REQ-005 SHALL have ports in0_valid/in1_valid  input  1 each  fetch slot valid.
REQ-006 SHALL have ports in0_instr/in1_instr  input  raw_instruction_t  fetched words.
REQ-007 SHALL have ports in0_pc/in1_pc  input  pc_t  fetch PCs.
REQ-008 SHALL have ports in0_bhsr/in1_bhsr  input  BHSR_t  branch history per slot.
REQ-009 SHALL have port in_ready  output  1  high when at least 2 entries are free.
REQ-010 SHALL have ports out0_valid/out1_valid  output  1 each  head and head+1 present.
REQ-011 SHALL have ports out0_instr/out1_instr, out0_pc/out1_pc, out0_bhsr/out1_bhsr  output  same types  head entries for decode.
REQ-012 SHALL have port dec_take  input  2  entries consumed by decode this cycle (0..2).
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL write on a rising clk edge only when in_ready=1 and flush=0; inputs with in_ready=0 are dropped and upstream holds them.
REQ-015 SHALL compact writes: with in0_valid=0 and in1_valid=1, slot 1 is written at tail; with both valid, slot 0 at tail, slot 1 at tail+1.
REQ-016 SHALL present out0 = entry at head and out1 = entry at head+1 directly from storage; write-to-output latency exactly 1 cycle, no same-cycle bypass.
REQ-017 SHALL drive out0_valid = (count>=1), out1_valid = (count>=2).
REQ-018 SHALL advance head by min(dec_take, count); dec_take larger than the valid output count is clamped, never underflows.
REQ-019 SHALL allow write and take in the same cycle; count_next = count + writes - takes.
REQ-020 SHALL wrap head and tail pointers modulo DEPTH.
REQ-021 SHALL drive in_ready = (DEPTH - count >= 2), combinational from registered count.
REQ-022 SHALL on flush=1 set head, tail and count to 0 at the next edge; flush wins over simultaneous write and take.
REQ-023 SHALL preserve program order: out0 is always older than out1.

Reset
REQ-024 SHALL asynchronously clear head, tail and count on rst_n=0; outputs out*_valid=0, in_ready=1, count=0 while reset is asserted.
REQ-025 SHALL leave storage contents unreset; data outputs are don't-care while out*_valid=0.
REQ-026 SHALL abandon any in-progress write or take when reset asserts mid-cycle.

Configuration
REQ-027 SHALL, with FALCO_IFB_STATS_EN defined, add outputs stall_cycles (32) counting cycles with in_ready=0 and any in*_valid=1, and flush_count (32) counting flush cycles; both saturate at 0xFFFFFFFF and reset to 0.
REQ-028 SHALL, without FALCO_IFB_STATS_EN, omit both ports and counters entirely.

Structure
REQ-029 SHALL add typedef fetch_entry_t {raw_instruction_t instr; pc_t pc; BHSR_t bhsr} and constant IFB_DEPTH=8 to Falco_pkg, reusing raw_instruction_t, pc_t and BHSR_t there.
REQ-030 SHALL contain one sub-module ifb_entry_ram: DEPTH x fetch_entry_t register array, 2 write ports, 2 combinational read ports.

Verification
REQ-031 SHALL cover: reset, then write both slots PC 0x100/0x104 -> next cycle out0_pc=0x100, out1_pc=0x104, count=2.
REQ-032 SHALL cover: only in1_valid with PC 0x204 into an empty buffer -> out0_pc=0x204, out1_valid=0, count=1.
REQ-033 SHALL cover: fill DEPTH=8 with 4 dual writes -> count=8, in_ready=0; further writes dropped; dec_take=2 -> in_ready=1 next cycle.
REQ-034 SHALL cover: 20 back-to-back dual writes with dec_take=2 every cycle -> strict PC order across pointer wrap, count constant at 2.
REQ-035 SHALL cover: flush with simultaneous dual write and dec_take=1 at count=5 -> count=0, out0_valid=0 next cycle.
REQ-036 SHALL cover: dec_take=2 with count=1 -> count=0, no underflow; rst_n low mid-stream -> count=0 immediately.
